// File: rtl/clock_divider_bank.sv
// Bank of runtime-programmable clock-enable dividers: one-cycle tick and 50% square per channel.
// Outputs are registered one cycle after terminal count; writes are always accepted with no backpressure.
module clock_divider_bank #(
  parameter int          CHANNELS        = 4,
  parameter int          WIDTH           = 12,
  parameter int          CHANNEL_BITS    = 2,
  parameter int unsigned DEFAULT_DIVISOR = 3071
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clock_valid,
  input  logic [CHANNELS-1:0]     channel_enable,
  input  logic                    sync_restart,
  input  logic                    write,
  input  logic [CHANNEL_BITS-1:0] write_channel,
  input  logic [WIDTH-1:0]        write_data,
  output logic [CHANNELS-1:0]     tick,
  output logic [CHANNELS-1:0]     square,
  output logic [CHANNELS-1:0]     pending
);

  localparam logic [WIDTH-1:0] RESET_DIVISOR = DEFAULT_DIVISOR[WIDTH-1:0];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] shadow;
    logic             pending_r;
    logic             tick_r;
    logic             square_r;
    logic             enabled;
    logic             advancing;
    logic             terminal;
    logic             write_hit;
    logic             defer_write;

    // Out-of-range channel numbers never match any generated index.
    assign write_hit   = write && (write_channel == CHANNEL_BITS'(i));
    assign enabled     = channel_enable[i];
    assign advancing   = clock_valid && enabled;
    assign terminal    = advancing && (count == active);
    // Mid-period writes to a running (or frozen) channel are queued so active never drops below count.
    assign defer_write = enabled && !terminal;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        count     <= '0;
        active    <= RESET_DIVISOR;
        shadow    <= RESET_DIVISOR;
        pending_r <= 1'b0;
        tick_r    <= 1'b0;
        square_r  <= 1'b0;
      end else if (sync_restart) begin
        count    <= '0;
        tick_r   <= 1'b0;
        square_r <= 1'b0;
        if (write_hit) begin
          active <= write_data;
          shadow <= write_data;
        end else if (pending_r) begin
          active <= shadow;
        end
        pending_r <= 1'b0;
      end else begin
        if (!enabled) begin
          count    <= '0;
          tick_r   <= 1'b0;
          square_r <= 1'b0;
        end else if (!clock_valid) begin
          tick_r <= 1'b0;
        end else if (terminal) begin
          count    <= '0;
          tick_r   <= 1'b1;
          square_r <= ~square_r;
          if (pending_r) begin
            active    <= shadow;
            pending_r <= 1'b0;
          end
        end else begin
          count  <= count + 1'b1;
          tick_r <= 1'b0;
        end

        // A write overrides the terminal-count swap above.
        if (write_hit) begin
          shadow <= write_data;
          if (defer_write) begin
            pending_r <= 1'b1;
          end else begin
            active    <= write_data;
            pending_r <= 1'b0;
          end
        end
      end
    end

    assign tick[i]    = tick_r;
    assign square[i]  = square_r;
    assign pending[i] = pending_r;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: fixed divisor periods, queued/immediate writes,
// sync restart phasing, clock_valid freeze, out-of-range writes and async reset.
module tb_clock_divider_bank;

  localparam int CH = 4;
  localparam int W  = 12;
  localparam int CB = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clock_valid = 1'b1;
  logic [CH-1:0] channel_enable = '1;
  logic          sync_restart = 1'b0;
  logic          write = 1'b0;
  logic [CB-1:0] write_channel = '0;
  logic [W-1:0]  write_data = '0;
  logic [CH-1:0] tick;
  logic [CH-1:0] square;
  logic [CH-1:0] pending;

  int checks = 0;
  int errors = 0;
  logic [CH-1:0] square_snap;

  clock_divider_bank #(
    .CHANNELS(CH), .WIDTH(W), .CHANNEL_BITS(CB), .DEFAULT_DIVISOR(3071)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clock_valid(clock_valid),
    .channel_enable(channel_enable), .sync_restart(sync_restart),
    .write(write), .write_channel(write_channel), .write_data(write_data),
    .tick(tick), .square(square), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int chn, input int d);
    write         = 1'b1;
    write_channel = CB'(chn);
    write_data    = W'(d);
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_square", 32'(square), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    reset_n = 1'b1;

    // Default divisor 3071: tick every 3072 cycles, square period 6144
    step(3071);
    chk("def_pre_tick", 32'(tick), 32'h0);
    step(1);
    chk("def_first_tick", 32'(tick), 32'hF);
    chk("def_square_hi", 32'(square), 32'hF);
    step(1);
    chk("def_tick_onecycle", 32'(tick), 32'h0);
    step(3070);
    chk("def_pre_second", 32'(tick), 32'h0);
    step(1);
    chk("def_second_tick", 32'(tick), 32'hF);
    chk("def_square_lo", 32'(square), 32'h0);

    // ch1 D=3 written at count 1000: queued until terminal
    step(1000);
    do_write(1, 3);
    step(1);
    write = 1'b0;
    chk("q_pending_set", 32'(pending), 32'h2);
    chk("q_no_tick", 32'(tick), 32'h0);
    step(2070);
    chk("q_pending_hold", 32'(pending), 32'h2);
    chk("q_pre_terminal", 32'(tick), 32'h0);
    step(1);
    chk("q_terminal_tick", 32'(tick), 32'hF);
    chk("q_pending_clr", 32'(pending), 32'h0);
    step(3);
    chk("q_ch1_gap", 32'(tick), 32'h0);
    step(1);
    chk("q_ch1_period4", 32'(tick), 32'h2);

    // ch2 D=0 written on its terminal cycle: immediate
    step(3067);
    do_write(2, 0);
    step(1);
    write = 1'b0;
    chk("imm_terminal_tick", 32'(tick), 32'hF);
    chk("imm_no_pending", 32'(pending), 32'h0);
    step(1);
    chk("imm_d0_tick1", 32'(tick), 32'h4);
    chk("imm_d0_sq1", 32'(square[2]), 32'h1);
    step(1);
    chk("imm_d0_tick2", 32'(tick), 32'h4);
    chk("imm_d0_sq2", 32'(square[2]), 32'h0);

    // ch3 D=4 queued, then ch0 D=9 written together with sync_restart
    do_write(3, 4);
    step(1);
    chk("sr_pending_ch3", 32'(pending), 32'h8);
    do_write(0, 9);
    sync_restart = 1'b1;
    step(1);
    write = 1'b0;
    sync_restart = 1'b0;
    chk("sr_pending_clr", 32'(pending), 32'h0);
    chk("sr_tick_clr", 32'(tick), 32'h0);
    chk("sr_square_clr", 32'(square), 32'h0);
    step(4);
    chk("sr_edge4", 32'(tick), 32'h6);
    step(1);
    chk("sr_edge5", 32'(tick), 32'hC);
    step(3);
    chk("sr_edge8", 32'(tick), 32'h6);
    step(1);
    chk("sr_edge9", 32'(tick), 32'h4);
    step(1);
    chk("sr_edge10", 32'(tick), 32'hD);
    step(10);
    chk("sr_edge20", 32'(tick), 32'hF);

    // Freeze for 50 cycles mid-period; out-of-range write to channel 5
    step(3);
    square_snap = square;
    clock_valid = 1'b0;
    do_write(5, 0);
    step(1);
    write = 1'b0;
    chk("frz_tick0", 32'(tick), 32'h0);
    step(49);
    chk("frz_tick_end", 32'(tick), 32'h0);
    chk("frz_square_hold", 32'(square), 32'(square_snap));
    chk("oor_no_pending", 32'(pending), 32'h0);
    clock_valid = 1'b1;
    step(1);
    chk("rsm_edge74", 32'(tick), 32'h6);
    step(1);
    chk("rsm_edge75", 32'(tick), 32'hC);
    step(4);
    chk("rsm_edge79", 32'(tick), 32'h4);
    step(1);
    chk("rsm_edge80", 32'(tick), 32'hD);
    chk("oor_pending_after", 32'(pending), 32'h0);

    // Async reset mid-period with a queued divisor on ch0
    do_write(0, 20);
    step(1);
    write = 1'b0;
    chk("ar_pending_set", 32'(pending), 32'h1);
    step(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_tick_clr", 32'(tick), 32'h0);
    chk("ar_square_clr", 32'(square), 32'h0);
    chk("ar_pending_clr", 32'(pending), 32'h0);
    step(2);
    reset_n = 1'b1;
    step(3071);
    chk("ar_default_pre", 32'(tick), 32'h0);
    step(1);
    chk("ar_default_tick", 32'(tick), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Parametrised, runtime-programmable bank of clock-enable generators; successor to the fixed-ratio clock divider.
- Each channel emits a one-cycle tick and a 50%-duty square wave derived from one fast clock.
- Divisors are reprogrammed glitch-free: new values take effect only at terminal count.
- Feeds sound, timer and I/O blocks that currently rely on hard-wired derived clocks.

Parameters:
CHANNELS, 4, number of independent divider channels
WIDTH, 12, divisor/counter width in bits
CHANNEL_BITS, 2, width of write_channel; must satisfy 2**CHANNEL_BITS >= CHANNELS
DEFAULT_DIVISOR, 3071, divisor loaded into every channel at reset

Ports:
clock  input  1  main clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
clock_valid  input  1  1 = source clock stable; 0 freezes all counting
channel_enable  input  CHANNELS  per-channel run enable, level-sensitive
sync_restart  input  1  one-cycle pulse; phase-aligns all channels
write  input  1  one-cycle divisor write strobe; always accepted
write_channel  input  CHANNEL_BITS  target channel of write
write_data  input  WIDTH  new divisor D
tick  output  CHANNELS  one-cycle pulse per period, registered
square  output  CHANNELS  toggles on every tick, registered
pending  output  CHANNELS  1 = written divisor queued, not yet active

Behaviour:
- Per-channel state: count[WIDTH], active[WIDTH], shadow[WIDTH], pending, tick, square.
- Reset (reset_n=0, async): count=0, active=shadow=DEFAULT_DIVISOR, pending=0, tick=0, square=0. This takes effect immediately, including mid-period or mid-write.
- Priority, highest first: reset_n, then sync_restart, then write, then counting.
- Counting: a channel advances when clock_valid=1 and channel_enable[i]=1.
  - If count != active: count <= count+1, tick <= 0.
  - If count == active (terminal): count <= 0, tick <= 1, square <= ~square. If pending=1: active <= shadow, pending <= 0.
  - Tick period = D+1 cycles. Square period = 2(D+1) cycles.
  - D=0: tick is high every advancing cycle and square toggles every cycle.
- Arithmetic: unsigned; count never exceeds active, so no wrap-around is needed. D = 2**WIDTH-1 is legal.
- clock_valid=0: count, square and active hold; tick <= 0. Writes are still accepted and follow the same rules.
- channel_enable[i]=0: count <= 0, tick <= 0, square <= 0. On re-enable, the first tick occurs after D+1 advancing cycles.
- Write (write=1, write_channel < CHANNELS):
  - Channel advancing and not at terminal: shadow <= write_data, pending <= 1. A second write before terminal overwrites shadow; last value wins.
  - Channel disabled, or this cycle is its terminal: active <= write_data and shadow <= write_data directly, pending <= 0. The terminal tick/square update still occurs.
  - write_channel >= CHANNELS: ignored, no state change.
- sync_restart=1: all channels count <= 0, tick <= 0, square <= 0.
  - Any pending shadow is copied to active and pending is cleared.
  - A write in the same cycle loads write_data directly into active of its target channel, pending <= 0.
  - Channels then tick in phase where their divisors allow.
- Outputs are pure register outputs with no combinational path from inputs.

Test Plan:
- Reset, CHANNELS=4, all enabled, clock_valid=1 -> each tick first high on cycle 3072 after reset release, then every 3072 cycles; square period 6144; pending=0.
- Write ch1 D=3 at count 1000 of a 3071 period -> pending[1]=1 until terminal, then tick[1] at period 3072 once more, then every 4 cycles; pending[1]=0 from terminal edge.
- Write ch2 D=0 during its terminal cycle -> applied immediately; tick[2] high every following cycle, square[2] toggles every cycle.
- ch0 D=9, ch3 D=4, pulse sync_restart -> both ticks coincide 10 cycles later and every 10 cycles thereafter (ch3 also at 5).
- clock_valid=0 for 50 cycles mid-period -> ticks stay 0, square holds; resume delays the next tick by exactly 50 cycles. Write to channel 5 (CHANNEL_BITS=3, CHANNELS=4) -> no state change.
- Assert reset_n low mid-period with pending[0]=1 -> all outputs 0 immediately, divisors revert to 3071.
